// File: rtl/fifo_rd_ptr_ctrl_if.sv
// Read-side bundle between the FIFO read-pointer controller and its neighbours.
// Signals:
//   read         consumer read request
//   g_wr_ptr     gray write pointer from the write side, unsynchronised
//   g_rd_ptr     registered gray read pointer returned to the write side
//   b_rd_ptr     registered binary read pointer
//   mem_rd_addr  storage read address
//   mem_rd_en    storage read strobe
//   rd_valid     storage data for the accepted read is valid this cycle
//   empty        no readable entries
//   almost_empty level at or below the almost-empty threshold
//   level        visible entry count
//   underflow    one-cycle pulse after a read request while empty
// Modports: slave = pointer controller, master = consumer/write-side view.
interface fifo_rd_ptr_ctrl_if #(
    parameter int unsigned N = 4
);
    logic         read;
    logic [N-1:0] g_wr_ptr;
    logic [N-1:0] g_rd_ptr;
    logic [N-1:0] b_rd_ptr;
    logic [N-2:0] mem_rd_addr;
    logic         mem_rd_en;
    logic         rd_valid;
    logic         empty;
    logic         almost_empty;
    logic [N-1:0] level;
    logic         underflow;

    modport slave (
        input  read,
        input  g_wr_ptr,
        output g_rd_ptr,
        output b_rd_ptr,
        output mem_rd_addr,
        output mem_rd_en,
        output rd_valid,
        output empty,
        output almost_empty,
        output level,
        output underflow
    );

    modport master (
        output read,
        output g_wr_ptr,
        input  g_rd_ptr,
        input  b_rd_ptr,
        input  mem_rd_addr,
        input  mem_rd_en,
        input  rd_valid,
        input  empty,
        input  almost_empty,
        input  level,
        input  underflow
    );
endinterface

// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-side pointer controller for the gray-coded FIFO.
// Synchronises the write side's gray pointer, derives empty/level/almost_empty,
// drives the storage read address/strobe and returns its own gray read pointer.
// Ports:
//   clk    sole clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    fifo_rd_ptr_ctrl_if.slave (read, g_wr_ptr in; pointers, flags, strobes out)
// Parameters:
//   N           pointer width (N-1 address bits plus wrap bit), depth = 2^(N-1)
//   SYNC_STAGES synchroniser depth on the incoming gray write pointer (2..3)
//   AE_THRESH   almost_empty asserted when level <= AE_THRESH
module fifo_rd_ptr_ctrl #(
    parameter int unsigned N           = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AE_THRESH   = 1
) (
    input logic               clk,
    input logic               reset,
    fifo_rd_ptr_ctrl_if.slave bus
);

    logic [N-1:0] sync_q [SYNC_STAGES];
    logic [N-1:0] g_wr_sync;
    logic [N-1:0] b_wr_sync;

    logic [N-1:0] b_rd_ptr_q, b_rd_ptr_d;
    logic [N-1:0] g_rd_ptr_q, g_rd_ptr_d;
    logic         rd_valid_q, underflow_q;
    logic         underflow_d;

    logic [N-1:0] b_rd_inc;
    logic [N-1:0] level;
    logic         empty;
    logic         accept;

    // Plain flop chain: nothing may sit between stages or the gray
    // single-bit-change guarantee across the crossing is lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= bus.g_wr_ptr;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign g_wr_sync = sync_q[SYNC_STAGES-1];

    // Gray to binary: bit i is the XOR of all gray bits at or above i.
    always_comb begin
        b_wr_sync = '0;
        for (int i = 0; i < int'(N); i++) begin
            b_wr_sync[i] = ^(g_wr_sync >> i);
        end
    end

    // Full-width compare: the wrap bit distinguishes empty from full.
    assign empty  = (b_wr_sync == b_rd_ptr_q);
    assign level  = b_wr_sync - b_rd_ptr_q;
    assign accept = bus.read && !empty;

    always_comb begin
        b_rd_inc    = b_rd_ptr_q + N'(1);
        b_rd_ptr_d  = b_rd_ptr_q;
        g_rd_ptr_d  = g_rd_ptr_q;
        underflow_d = bus.read && empty;
        if (accept) begin
            b_rd_ptr_d = b_rd_inc;
            g_rd_ptr_d = b_rd_inc ^ (b_rd_inc >> 1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b_rd_ptr_q  <= '0;
            g_rd_ptr_q  <= '0;
            rd_valid_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            b_rd_ptr_q  <= b_rd_ptr_d;
            g_rd_ptr_q  <= g_rd_ptr_d;
            rd_valid_q  <= accept;
            underflow_q <= underflow_d;
        end
    end

    assign bus.g_rd_ptr     = g_rd_ptr_q;
    assign bus.b_rd_ptr     = b_rd_ptr_q;
    assign bus.mem_rd_addr  = b_rd_ptr_q[N-2:0];
    assign bus.mem_rd_en    = accept;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.empty        = empty;
    assign bus.level        = level;
    assign bus.almost_empty = (32'(level) <= AE_THRESH);
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// Directed bench for fifo_rd_ptr_ctrl with N=4, SYNC_STAGES=2, AE_THRESH=1.
module tb_fifo_rd_ptr_ctrl;

    logic clk;
    logic reset;

    fifo_rd_ptr_ctrl_if #(.N(4)) bus ();

    fifo_rd_ptr_ctrl #(
        .N           (4),
        .SYNC_STAGES (2),
        .AE_THRESH   (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic       rd;
        logic [3:0] gw;
        logic       e_empty;
        logic [3:0] e_level;
        logic       e_ae;
        logic       e_en;
        logic [2:0] e_addr;
        logic [3:0] e_grd;
        logic       e_rv;
        logic       e_uf;
    } vec_t;

    vec_t vec [13];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a gray write pointer, then read until empty within a budget.
    task automatic drain_to(input logic [3:0] gw, input int exp_b);
        int n;
        bus.g_wr_ptr = gw;
        tick();
        tick();
        bus.read = 1'b1;
        #1;
        n = 0;
        while (!bus.empty && n < 20) begin
            tick();
            n++;
        end
        bus.read = 1'b0;
        chk("drain_budget", int'(bus.empty), 1);
        chk("drain_b_rd", int'(bus.b_rd_ptr), exp_b);
    endtask

    initial begin
        // rd gw    empty lvl ae en addr grd   rv uf
        vec[0]  = '{1'b0, 4'b0000, 1'b1, 4'd0, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0};
        vec[1]  = '{1'b0, 4'b0001, 1'b1, 4'd0, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0};
        vec[2]  = '{1'b0, 4'b0001, 1'b1, 4'd0, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0};
        vec[3]  = '{1'b0, 4'b0011, 1'b0, 4'd1, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0};
        vec[4]  = '{1'b0, 4'b0010, 1'b0, 4'd1, 1'b1, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0};
        vec[5]  = '{1'b0, 4'b0010, 1'b0, 4'd2, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0};
        vec[6]  = '{1'b1, 4'b0010, 1'b0, 4'd3, 1'b0, 1'b1, 3'd0, 4'b0000, 1'b0, 1'b0};
        vec[7]  = '{1'b1, 4'b0010, 1'b0, 4'd2, 1'b0, 1'b1, 3'd1, 4'b0001, 1'b1, 1'b0};
        vec[8]  = '{1'b1, 4'b0010, 1'b0, 4'd1, 1'b1, 1'b1, 3'd2, 4'b0011, 1'b1, 1'b0};
        vec[9]  = '{1'b0, 4'b0010, 1'b1, 4'd0, 1'b1, 1'b0, 3'd3, 4'b0010, 1'b1, 1'b0};
        vec[10] = '{1'b1, 4'b0010, 1'b1, 4'd0, 1'b1, 1'b0, 3'd3, 4'b0010, 1'b0, 1'b0};
        vec[11] = '{1'b0, 4'b0010, 1'b1, 4'd0, 1'b1, 1'b0, 3'd3, 4'b0010, 1'b0, 1'b1};
        vec[12] = '{1'b0, 4'b0010, 1'b1, 4'd0, 1'b1, 1'b0, 3'd3, 4'b0010, 1'b0, 1'b0};

        // Reset values with a non-zero write pointer already present.
        reset        = 1'b0;
        bus.read     = 1'b0;
        bus.g_wr_ptr = 4'b0110;
        tick();
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_level", int'(bus.level), 0);
        chk("rst_ae", int'(bus.almost_empty), 1);
        chk("rst_g_rd", int'(bus.g_rd_ptr), 0);
        chk("rst_rv", int'(bus.rd_valid), 0);
        chk("rst_en", int'(bus.mem_rd_en), 0);
        #2 reset = 1'b1;
        tick();
        chk("rel1_level", int'(bus.level), 0);
        tick();
        chk("rel2_level", int'(bus.level), 4);
        chk("rel2_empty", int'(bus.empty), 0);

        // Fresh reset with an idle write side, then the vector table.
        reset        = 1'b0;
        bus.g_wr_ptr = 4'b0000;
        tick();
        reset = 1'b1;
        tick();
        for (int k = 0; k < 13; k++) begin
            bus.read     = vec[k].rd;
            bus.g_wr_ptr = vec[k].gw;
            #2;
            chk($sformatf("v%0d_empty", k), int'(bus.empty), int'(vec[k].e_empty));
            chk($sformatf("v%0d_level", k), int'(bus.level), int'(vec[k].e_level));
            chk($sformatf("v%0d_ae", k), int'(bus.almost_empty), int'(vec[k].e_ae));
            chk($sformatf("v%0d_en", k), int'(bus.mem_rd_en), int'(vec[k].e_en));
            chk($sformatf("v%0d_addr", k), int'(bus.mem_rd_addr), int'(vec[k].e_addr));
            chk($sformatf("v%0d_g_rd", k), int'(bus.g_rd_ptr), int'(vec[k].e_grd));
            chk($sformatf("v%0d_rv", k), int'(bus.rd_valid), int'(vec[k].e_rv));
            chk($sformatf("v%0d_uf", k), int'(bus.underflow), int'(vec[k].e_uf));
            tick();
        end
        chk("uf_hold_b_rd", int'(bus.b_rd_ptr), 3);

        // Walk the read pointer up to 1111 (gray 1000).
        drain_to(4'b1111, 10);
        drain_to(4'b1000, 15);
        chk("pre_wrap_g_rd", int'(bus.g_rd_ptr), 4'b1000);

        // Write pointer at binary 0001: two entries straddling the wrap.
        bus.g_wr_ptr = 4'b0001;
        tick();
        tick();
        chk("wrap_level", int'(bus.level), 2);
        chk("wrap_addr0", int'(bus.mem_rd_addr), 7);
        bus.read = 1'b1;
        #1;
        chk("wrap_en0", int'(bus.mem_rd_en), 1);
        tick();
        chk("wrap_addr1", int'(bus.mem_rd_addr), 0);
        chk("wrap_en1", int'(bus.mem_rd_en), 1);
        chk("wrap_rv1", int'(bus.rd_valid), 1);
        tick();
        bus.read = 1'b0;
        chk("wrap_b_rd", int'(bus.b_rd_ptr), 1);
        chk("wrap_g_rd", int'(bus.g_rd_ptr), 4'b0001);
        chk("wrap_empty", int'(bus.empty), 1);
        tick();

        // Asynchronous reset between edges during a read burst.
        bus.g_wr_ptr = 4'b0101;
        tick();
        tick();
        chk("burst_level", int'(bus.level), 5);
        bus.read = 1'b1;
        tick();
        tick();
        chk("burst_rv", int'(bus.rd_valid), 1);
        chk("burst_b_rd", int'(bus.b_rd_ptr), 3);
        #1 reset = 1'b0;
        #1;
        chk("arst_b_rd", int'(bus.b_rd_ptr), 0);
        chk("arst_g_rd", int'(bus.g_rd_ptr), 0);
        chk("arst_rv", int'(bus.rd_valid), 0);
        chk("arst_uf", int'(bus.underflow), 0);
        chk("arst_empty", int'(bus.empty), 1);
        chk("arst_level", int'(bus.level), 0);
        chk("arst_en", int'(bus.mem_rd_en), 0);
        bus.read = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
